// File: rtl/led_status_scheduler_pkg.sv
// Shared definitions for the status LED scheduler: error FSM encoding,
// error-code width and default millisecond timing constants.
package led_status_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } err_state_e;

  localparam int unsigned ERR_CODE_W = 4;

  localparam int unsigned DEF_TICK_DIV = 50_000;
  localparam int unsigned DEF_HOLD_MS  = 100;
  localparam int unsigned DEF_ON_MS    = 150;
  localparam int unsigned DEF_OFF_MS   = 150;
  localparam int unsigned DEF_GAP_MS   = 600;
  localparam int unsigned DEF_BOOT_MS  = 500;

  // Largest of three values, used to size the shared blink timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: divider counts 0..TICK_DIV-1 and flags the
// last count for one cycle before wrapping.
// Ports: clock, reset (async, active-high), tick (one cycle per TICK_DIV clocks).
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Free-running divider
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Decode of the registered count; no extra latency relative to the divider.
  assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/led_status_scheduler.sv
// Status LED scheduler: shares one red/green LED between clip indication,
// blink-coded error reports and a bootloader heartbeat, fixed priority.
// Ports: clock, reset (async, active-high); clip_in, boot_mode, err_req,
// err_code[3:0] in; err_ack (1-cycle), busy, led_red, led_green out (registered).
module led_status_scheduler
  import led_status_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned HOLD_MS  = DEF_HOLD_MS,
  parameter int unsigned ON_MS    = DEF_ON_MS,
  parameter int unsigned OFF_MS   = DEF_OFF_MS,
  parameter int unsigned GAP_MS   = DEF_GAP_MS,
  parameter int unsigned BOOT_MS  = DEF_BOOT_MS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clip_in,
  input  logic                  boot_mode,
  input  logic                  err_req,
  input  logic [ERR_CODE_W-1:0] err_code,
  output logic                  err_ack,
  output logic                  busy,
  output logic                  led_red,
  output logic                  led_green
);

  localparam int unsigned TMR_W  = $clog2(max3(ON_MS, OFF_MS, GAP_MS) + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_MS + 1);
  localparam int unsigned BOOT_W = $clog2(BOOT_MS + 1);

  localparam logic [TMR_W-1:0]  ON_LD     = TMR_W'(ON_MS);
  localparam logic [TMR_W-1:0]  OFF_LD    = TMR_W'(OFF_MS);
  localparam logic [TMR_W-1:0]  GAP_LD    = TMR_W'(GAP_MS);
  localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(HOLD_MS);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_MS - 1);

  logic tick;

  err_state_e            state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [ERR_CODE_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;
  logic                  boot_flag_q, boot_flag_d;
  logic                  timer_expire;
  logic                  ack_d, busy_d, red_d, green_d;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      boot_cnt_q  <= '0;
      boot_flag_q <= 1'b0;
      err_ack     <= 1'b0;
      busy        <= 1'b0;
      led_red     <= 1'b0;
      led_green   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_flag_q <= boot_flag_d;
      err_ack     <= ack_d;
      busy        <= busy_d;
      led_red     <= red_d;
      led_green   <= green_d;
    end
  end

  // Next-state for error FSM, clip hold, heartbeat and LED priority mux
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    boot_cnt_d   = boot_cnt_q;
    boot_flag_d  = boot_flag_q;
    ack_d        = 1'b0;
    red_d        = 1'b0;
    green_d      = 1'b0;
    timer_expire = tick && (timer_q == TMR_W'(1));

    if (tick && (timer_q != '0)) begin
      timer_d = timer_q - TMR_W'(1);
    end

    // The registered ack gates acceptance so a request still held during
    // the ack cycle is not acknowledged twice.
    case (state_q)
      ST_IDLE: begin
        if (err_req && !err_ack) begin
          ack_d = 1'b1;
          if (err_code != '0) begin
            cnt_d   = err_code;
            timer_d = ON_LD;
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (timer_expire) begin
          timer_d = OFF_LD;
          cnt_d   = (cnt_q != '0) ? cnt_q - ERR_CODE_W'(1) : '0;
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (timer_expire) begin
          if (cnt_q != '0) begin
            timer_d = ON_LD;
            state_d = ST_ON;
          end else begin
            timer_d = GAP_LD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (timer_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Retriggerable clip stretch
    if (clip_in) begin
      hold_d = HOLD_LD;
    end else if (tick && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    // Heartbeat runs only in boot mode and restarts from phase 0 on entry
    if (!boot_mode) begin
      boot_cnt_d  = '0;
      boot_flag_d = 1'b0;
    end else if (tick) begin
      if (boot_cnt_q == BOOT_LAST) begin
        boot_cnt_d  = '0;
        boot_flag_d = !boot_flag_q;
      end else begin
        boot_cnt_d = boot_cnt_q + BOOT_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);

    // Priority mux on next-state values gives one cycle input-to-pin latency
    if (hold_d != '0) begin
      red_d = 1'b1;
    end else begin
      case (state_d)
        ST_ON:   red_d   = 1'b1;
        ST_IDLE: green_d = boot_mode ? boot_flag_d : 1'b1;
        default: begin
          red_d   = 1'b0;
          green_d = 1'b0;
        end
      endcase
    end
  end

endmodule
